regfile_wb_arbiter: RTL

//   Shares the single register-file write port among NREQ write-back sources (ALU, mult/div, load).
//   - Arbitrates round-robin and registers the winning rd/data into one write stage.
//   - Drives the regfile write port directly, including its 32-bit one-hot write select.
//   - Keeps a 32-entry pending-write scoreboard so the hazard logic can stall readers.

---
 rtl/regfile_wb_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter driving the single regfile write port, with a pending-write scoreboard.
// Optional bypass outputs (byp_valid/byp_addr) are enabled by defining WB_BYPASS_EN.
module regfile_wb_arbiter #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 hold,
    input  logic                 rsv_en,
    input  logic [AW-1:0]        rsv_addr,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_addr,
    output logic [(2**AW)-1:0]   wr_sel,
    output logic [DW-1:0]        wr_data,
    output logic [(2**AW)-1:0]   busy
`ifdef WB_BYPASS_EN
    ,
    output logic                 byp_valid,
    output logic [AW-1:0]        byp_addr
`endif
);

    localparam int unsigned NREG = 2 ** AW;
    localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr_q, ptr_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic [NREG-1:0] busy_q, busy_d;

    logic [NREQ-1:0] grant;
    logic [PW-1:0]   win_idx;
    logic            xfer;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_data;

    // Scan from ptr upward (mod NREQ); the first valid requester wins.
    always_comb begin : arbitrate
        logic [PW-1:0] cand;
        grant   = '0;
        win_idx = '0;
        xfer    = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = PW'((32'(ptr_q) + k) % NREQ);
            if (!xfer && req_valid[cand]) begin
                xfer        = 1'b1;
                grant[cand] = 1'b1;
                win_idx     = cand;
            end
        end
        if (hold || !reset_n) begin
            grant = '0;
            xfer  = 1'b0;
        end
    end

    assign req_ready = grant;
    assign win_addr  = req_addr[32'(win_idx)*AW +: AW];
    assign win_data  = req_data[32'(win_idx)*DW +: DW];

    always_comb begin
        ptr_d     = ptr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (xfer) begin
            ptr_d     = PW'((32'(win_idx) + 1) % NREQ);
            wr_en_d   = (win_addr != '0);
            wr_addr_d = win_addr;
            wr_data_d = win_data;
        end
    end

    // Set after clear so a reservation at the commit edge (a newer writer) wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_en_q) busy_d[wr_addr_q] = 1'b0;
        if (rsv_en)  busy_d[rsv_addr]  = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ptr_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
        end else begin
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign wr_sel  = wr_en_q ? (NREG'(1) << wr_addr_q) : '0;
    assign busy    = busy_q;

`ifdef WB_BYPASS_EN
    assign byp_valid = wr_en_q && (wr_addr_q != '0);
    assign byp_addr  = wr_addr_q;
`endif

endmodule
